// File: rtl/bitrev_reorder_buf.sv
// Bit-reversal reorder buffer for the radix-2 SDF FFT output stream.
// Accepts a serial frame of 2^N complex samples in bit-reversed order and
// replays it in natural bin order. Two banks ping-pong so that one frame can
// be filled while the previous one drains, at one sample per clock.
// Optional macro FRAME_ERR_EN adds a registered frame_err pulse output that
// flags aborted partial frames and dropped orphan samples.
module bitrev_reorder_buf #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ip_valid,
    input  logic         start_ip,
    input  logic [W-1:0] ip_re,
    input  logic [W-1:0] ip_im,
    output logic         op_valid,
    output logic         start_op,
    output logic [W-1:0] op_re,
    output logic [W-1:0] op_im
`ifdef FRAME_ERR_EN
    ,
    output logic         frame_err
`endif
);

    localparam int unsigned Depth = 1 << N;
    localparam logic [N-1:0] LastIdx = N'(Depth - 1);

    typedef enum logic {
        WIdle,
        WFill
    } wstate_e;

    typedef enum logic {
        RIdle,
        RDrain
    } rstate_e;

    // Reverse the N LSBs of an index.
    function automatic logic [N-1:0] bitrev(input logic [N-1:0] k);
        logic [N-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
            r[i] = k[int'(N) - 1 - i];
        end
        return r;
    endfunction

    // Sample storage: two banks, each holding {re, im}; no reset needed.
    logic [2*W-1:0] mem_q [2][Depth];

    wstate_e      wstate_q, wstate_d;
    logic [N-1:0] wcnt_q, wcnt_d;
    logic         wbank_q, wbank_d;
    logic         we;
    logic [N-1:0] waddr;
    logic         handoff;

    rstate_e      rstate_q, rstate_d;
    logic [N-1:0] raddr_q, raddr_d;
    logic         rbank_q, rbank_d;

    logic         op_valid_q, op_valid_d;
    logic         start_op_q, start_op_d;
    logic [W-1:0] op_re_q, op_re_d;
    logic [W-1:0] op_im_q, op_im_d;

    // Write side: place each accepted sample at its natural-order address.
    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        wbank_d  = wbank_q;
        we       = 1'b0;
        waddr    = bitrev(wcnt_q);
        handoff  = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                // Samples without a frame start are dropped here.
                if (ip_valid && start_ip) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wcnt_d   = N'(1);
                    wstate_d = WFill;
                end
            end
            WFill: begin
                if (ip_valid) begin
                    we = 1'b1;
                    if (start_ip) begin
                        // Abort the partial frame and restart in the same bank.
                        waddr  = '0;
                        wcnt_d = N'(1);
                    end else begin
                        waddr  = bitrev(wcnt_q);
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == LastIdx) begin
                            wbank_d  = ~wbank_q;
                            handoff  = 1'b1;
                            wcnt_d   = '0;
                            wstate_d = WIdle;
                        end
                    end
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    // Read side: drain the handed-off bank in address order with registered outputs.
    always_comb begin
        rstate_d   = rstate_q;
        raddr_d    = raddr_q;
        rbank_d    = rbank_q;
        op_valid_d = 1'b0;
        start_op_d = 1'b0;
        op_re_d    = op_re_q;
        op_im_d    = op_im_q;
        unique case (rstate_q)
            RIdle: begin
                if (handoff) begin
                    rstate_d = RDrain;
                    raddr_d  = '0;
                    rbank_d  = wbank_q;
                end
            end
            RDrain: begin
                {op_re_d, op_im_d} = mem_q[rbank_q][raddr_q];
                op_valid_d         = 1'b1;
                start_op_d         = (raddr_q == '0);
                raddr_d            = raddr_q + 1'b1;
                if (raddr_q == LastIdx) begin
                    // A fill can only complete on the last drain cycle at the
                    // earliest, so back-to-back frames chain here with no gap.
                    if (handoff) begin
                        raddr_d = '0;
                        rbank_d = wbank_q;
                    end else begin
                        rstate_d = RIdle;
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    // Bank write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wbank_q][waddr] <= {ip_re, ip_im};
        end
    end

    // Control and output state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q   <= WIdle;
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
            rstate_q   <= RIdle;
            raddr_q    <= '0;
            rbank_q    <= 1'b0;
            op_valid_q <= 1'b0;
            start_op_q <= 1'b0;
            op_re_q    <= '0;
            op_im_q    <= '0;
        end else begin
            wstate_q   <= wstate_d;
            wcnt_q     <= wcnt_d;
            wbank_q    <= wbank_d;
            rstate_q   <= rstate_d;
            raddr_q    <= raddr_d;
            rbank_q    <= rbank_d;
            op_valid_q <= op_valid_d;
            start_op_q <= start_op_d;
            op_re_q    <= op_re_d;
            op_im_q    <= op_im_d;
        end
    end

    assign op_valid = op_valid_q;
    assign start_op = start_op_q;
    assign op_re    = op_re_q;
    assign op_im    = op_im_q;

`ifdef FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Flag an aborted partial frame or a dropped orphan sample.
    always_comb begin
        frame_err_d = ip_valid &&
                      (((wstate_q == WIdle) && !start_ip) ||
                       ((wstate_q == WFill) && start_ip));
    end

    // One-cycle registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule
